// File: rtl/vector_store_serializer_if.sv
// Handshake bundle between the vector ALU and the serializer, and between
// the serializer and the data-memory write port.
interface vector_store_serializer_if #(
  parameter int LANES  = 4,
  parameter int LANE_W = 32,
  parameter int ADDR_W = 32
);
  logic                    vec_valid;
  logic                    vec_ready;
  logic [LANES*LANE_W-1:0] vec_data;
  logic [ADDR_W-1:0]       vec_addr;
  logic [LANES-1:0]        lane_mask;
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_addr;
  logic [LANE_W-1:0]       mem_wdata;
  logic                    mem_ack;
  logic                    busy;
  logic                    done;

  // Serializer side.
  modport slave (
    input  vec_valid, vec_data, vec_addr, lane_mask, mem_ack,
    output vec_ready, mem_we, mem_addr, mem_wdata, busy, done
  );

  // Upstream pipeline plus memory side.
  modport master (
    output vec_valid, vec_data, vec_addr, lane_mask, mem_ack,
    input  vec_ready, mem_we, mem_addr, mem_wdata, busy, done
  );
endinterface

// File: rtl/vector_store_serializer.sv
// Serializes a captured LANES x LANE_W vector into masked word stores,
// lowest lane first, holding each store until the memory acknowledges it.
module vector_store_serializer #(
  parameter int LANES  = 4,
  parameter int LANE_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  vector_store_serializer_if.slave    bus
);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  state_t                  r_state, w_state_nxt;
  logic [LANES*LANE_W-1:0] r_data;
  logic [ADDR_W-1:0]       r_base;
  logic [LANES-1:0]        r_pend, w_pend_nxt;
  logic                    r_done, w_done_nxt;
  logic                    w_accept;
  logic [LW-1:0]           w_lane;
  logic                    w_found;
  logic [LANES-1:0]        w_lane_bit;
  logic                    w_last;

  // r_pend holds the lanes still to be written; the current lane is its lowest set bit.
  always_comb begin
    w_lane  = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (r_pend[i] && !w_found) begin
        w_lane  = i[LW-1:0];
        w_found = 1'b1;
      end
    end
  end

  assign w_lane_bit = LANES'(1) << w_lane;
  assign w_last     = (r_pend & ~w_lane_bit) == '0;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pend_nxt    = r_pend;
    w_done_nxt    = 1'b0;
    w_accept      = 1'b0;
    bus.vec_ready = 1'b0;
    bus.mem_we    = 1'b0;
    bus.busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.vec_ready = ~rst;
        w_accept      = bus.vec_valid & ~rst;
        if (w_accept) begin
          w_pend_nxt = bus.lane_mask;
          if (bus.lane_mask != '0) w_state_nxt = S_WRITE;
          else                     w_done_nxt  = 1'b1;
        end
      end
      S_WRITE: begin
        bus.mem_we = 1'b1;
        bus.busy   = 1'b1;
        if (bus.mem_ack) begin
          w_pend_nxt = r_pend & ~w_lane_bit;
          if (w_last) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
      r_done <= 1'b0;
      r_data <= '0;
      r_base <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      r_done <= w_done_nxt;
      if (w_accept) begin
        r_data <= bus.vec_data;
        r_base <= bus.vec_addr;
      end
    end
  end

  // Address adds wrap naturally at ADDR_W bits.
  assign bus.mem_addr  = (r_state == S_WRITE) ? r_base + ADDR_W'({w_lane, 2'b00}) : '0;
  assign bus.mem_wdata = (r_state == S_WRITE) ? r_data[w_lane*LANE_W +: LANE_W] : '0;
  assign bus.done      = r_done;
endmodule

// File: tb/tb_vector_store_serializer.sv
// Directed bench: stimulus pushes expected stores into a scoreboard queue,
// a negedge monitor pops and compares every acknowledged store.
module tb_vector_store_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vector_store_serializer_if #(.LANES(4), .LANE_W(32), .ADDR_W(32)) bus ();

  vector_store_serializer #(.LANES(4), .LANE_W(32), .ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks   = 0;
  int          errors   = 0;
  int          done_cnt = 0;
  logic        mon_en   = 1'b0;
  logic [63:0] exp_q[$];

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.done) done_cnt++;
      if (bus.mem_we && bus.mem_ack) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL store_unexpected got addr=%h data=%h required none", bus.mem_addr, bus.mem_wdata);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          if ({bus.mem_addr, bus.mem_wdata} !== e) begin
            errors++;
            $display("FAIL store got addr=%h data=%h required addr=%h data=%h",
                     bus.mem_addr, bus.mem_wdata, e[63:32], e[31:0]);
          end
        end
      end
      if (!bus.mem_we) begin
        checks++;
        if (bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
          errors++;
          $display("FAIL idle_bus got addr=%h data=%h required 0/0", bus.mem_addr, bus.mem_wdata);
        end
      end
    end
  end

  // Samples {we,ready,busy,done} mid-cycle, then advances to just after the next edge.
  task automatic cyc_check(input string nm, input logic [3:0] exp);
    @(negedge clk);
    checks++;
    if ({bus.mem_we, bus.vec_ready, bus.busy, bus.done} !== exp) begin
      errors++;
      $display("FAIL %s got we/rdy/busy/done=%b required %b", nm,
               {bus.mem_we, bus.vec_ready, bus.busy, bus.done}, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic hold_check(input string nm, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    checks++;
    if (bus.mem_addr !== a || bus.mem_wdata !== d) begin
      errors++;
      $display("FAIL %s got addr=%h data=%h required addr=%h data=%h", nm,
               bus.mem_addr, bus.mem_wdata, a, d);
    end
  endtask

  task automatic present(input logic [127:0] d, input logic [31:0] a, input logic [3:0] m);
    bus.vec_valid = 1'b1;
    bus.vec_data  = d;
    bus.vec_addr  = a;
    bus.lane_mask = m;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.vec_valid = 1'b0;
    bus.vec_data  = '0;
    bus.vec_addr  = '0;
    bus.lane_mask = '0;
    bus.mem_ack   = 1'b0;

    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.vec_ready, bus.mem_we, bus.busy, bus.done} !== 4'b0000 ||
        bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_state got rdy/we/busy/done=%b addr=%h data=%h required 0000 0 0",
               {bus.vec_ready, bus.mem_we, bus.busy, bus.done}, bus.mem_addr, bus.mem_wdata);
    end
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    // 1: full mask, ack tied high
    bus.mem_ack = 1'b1;
    present({32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 32'h100, 4'b1111);
    exp_q.push_back({32'h100, 32'h11111111});
    exp_q.push_back({32'h104, 32'h22222222});
    exp_q.push_back({32'h108, 32'h33333333});
    exp_q.push_back({32'h10C, 32'h44444444});
    cyc_check("t1_accept", 4'b0100);
    bus.vec_valid = 1'b0;
    for (int i = 0; i < 4; i++) cyc_check("t1_write", 4'b1010);
    cyc_check("t1_done", 4'b0101);
    cyc_check("t1_after", 4'b0100);

    // 2: sparse mask
    present({32'hAAAA0003, 32'hAAAA0002, 32'hAAAA0001, 32'hAAAA0000}, 32'h200, 4'b1010);
    exp_q.push_back({32'h204, 32'hAAAA0001});
    exp_q.push_back({32'h20C, 32'hAAAA0003});
    cyc_check("t2_accept", 4'b0100);
    bus.vec_valid = 1'b0;
    for (int i = 0; i < 2; i++) cyc_check("t2_write", 4'b1010);
    cyc_check("t2_done", 4'b0101);

    // 3: backpressure on lane 0
    present({32'h33330003, 32'h33330002, 32'h33330001, 32'h33330000}, 32'h300, 4'b0011);
    exp_q.push_back({32'h300, 32'h33330000});
    exp_q.push_back({32'h304, 32'h33330001});
    cyc_check("t3_accept", 4'b0100);
    bus.vec_valid = 1'b0;
    bus.mem_ack   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      hold_check("t3_hold", 32'h300, 32'h33330000);
      cyc_check("t3_stall", 4'b1010);
    end
    bus.mem_ack = 1'b1;
    cyc_check("t3_lane0", 4'b1010);
    cyc_check("t3_lane1", 4'b1010);
    cyc_check("t3_done", 4'b0101);

    // 4: zero mask
    present(128'hDEAD, 32'h400, 4'b0000);
    cyc_check("t4_accept", 4'b0100);
    bus.vec_valid = 1'b0;
    cyc_check("t4_done", 4'b0101);
    cyc_check("t4_after", 4'b0100);

    // 5: back-to-back, inputs changed mid-store
    present({32'h5A5A0003, 32'h5A5A0002, 32'h5A5A0001, 32'h5A5A0000}, 32'h400, 4'b1111);
    exp_q.push_back({32'h400, 32'h5A5A0000});
    exp_q.push_back({32'h404, 32'h5A5A0001});
    exp_q.push_back({32'h408, 32'h5A5A0002});
    exp_q.push_back({32'h40C, 32'h5A5A0003});
    exp_q.push_back({32'h500, 32'hB0B00000});
    exp_q.push_back({32'h508, 32'hB0B00002});
    cyc_check("t5_accept_a", 4'b0100);
    present({32'hB0B00003, 32'hB0B00002, 32'hB0B00001, 32'hB0B00000}, 32'h500, 4'b0101);
    for (int i = 0; i < 4; i++) cyc_check("t5_write_a", 4'b1010);
    cyc_check("t5_done_a_accept_b", 4'b0101);
    bus.vec_valid = 1'b0;
    for (int i = 0; i < 2; i++) cyc_check("t5_write_b", 4'b1010);
    cyc_check("t5_done_b", 4'b0101);

    // 6: wrap, then reset mid-store
    present({32'h66660003, 32'h66660002, 32'h66660001, 32'h66660000}, 32'hFFFFFFFC, 4'b1111);
    exp_q.push_back({32'hFFFFFFFC, 32'h66660000});
    exp_q.push_back({32'h00000000, 32'h66660001});
    cyc_check("t6_accept", 4'b0100);
    bus.vec_valid = 1'b0;
    for (int i = 0; i < 2; i++) cyc_check("t6_write", 4'b1010);
    rst         = 1'b1;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.vec_ready !== 1'b0) begin
      errors++;
      $display("FAIL t6_ready_in_reset got %b required 0", bus.vec_ready);
    end
    @(posedge clk);
    #1;
    rst         = 1'b0;
    bus.mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) cyc_check("t6_post_reset", 4'b0100);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL stores_missing got %0d pending required 0", exp_q.size());
    end
    checks++;
    if (done_cnt != 6) begin
      errors++;
      $display("FAIL done_count got %0d required 6", done_cnt);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
